// File: rtl/tuner_pkg.sv
// Shared tuner constants: peak-picker FSM encoding, Q16.16 helpers,
// default magnitude width and reference note frequencies used by the tuner.
package tuner_pkg;

    localparam logic [1:0] ST_SCAN = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    localparam int          Q16_FRAC_BITS = 16;
    localparam logic [31:0] Q16_ROUND     = 32'h0000_8000;

    localparam int DEFAULT_MAG_WIDTH = 24;

    // Standard guitar tuning plus A4 reference, integer Hz.
    localparam int NOTE_E2_HZ = 82;
    localparam int NOTE_A2_HZ = 110;
    localparam int NOTE_D3_HZ = 147;
    localparam int NOTE_G3_HZ = 196;
    localparam int NOTE_B3_HZ = 247;
    localparam int NOTE_E4_HZ = 330;
    localparam int NOTE_A4_HZ = 440;

endpackage

// File: rtl/bin_to_hz.sv
// Bin index to integer Hz: registered index x Q16.16 bin width, then round/shift.
// Ports: clk, reset (sync, active-high), load (capture product), index in, freq out.
module bin_to_hz
    import tuner_pkg::*;
#(
    parameter int          INDEX_WIDTH   = 11,
    parameter int          FREQ_WIDTH    = INDEX_WIDTH + 16,
    parameter logic [31:0] BIN_WIDTH_Q16 = 32'h0001_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [INDEX_WIDTH-1:0] index,
    output logic [FREQ_WIDTH-1:0]  freq
);

    localparam int PW = INDEX_WIDTH + 32;

    logic [PW-1:0] product;

    always_ff @(posedge clk) begin
        if (reset) begin
            product <= '0;
        end else if (load) begin
            product <= {32'b0, index} * {{INDEX_WIDTH{1'b0}}, BIN_WIDTH_Q16};
        end
    end

    // One spare bit so the rounding add can never wrap.
    assign freq = FREQ_WIDTH'(({1'b0, product} + (PW+1)'(Q16_ROUND))
                              >> Q16_FRAC_BITS);

endmodule

// File: rtl/spectral_peak_picker.sv
// Finds the largest in-window FFT bin of each frame and reports it in Hz.
// Ports: clk, reset, mag_data/mag_valid/mag_last/mag_ready stream in;
// freq_out/freq_valid/peak_mag level outputs, frame_overrun pulse.
module spectral_peak_picker
    import tuner_pkg::*;
#(
    parameter int          INDEX_WIDTH   = 11,
    parameter int          FREQ_WIDTH    = INDEX_WIDTH + 16,
    parameter int          MAG_WIDTH     = DEFAULT_MAG_WIDTH,
    parameter logic [31:0] BIN_WIDTH_Q16 = 32'h0001_0000,
    parameter int          MIN_BIN       = 20,
    parameter int          MAX_BIN       = 400,
    parameter int          MIN_MAG       = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [MAG_WIDTH-1:0]   mag_data,
    input  logic                   mag_valid,
    input  logic                   mag_last,
    output logic                   mag_ready,
    output logic [FREQ_WIDTH-1:0]  freq_out,
    output logic                   freq_valid,
    output logic [MAG_WIDTH-1:0]   peak_mag,
    output logic                   frame_overrun
);

    localparam logic [INDEX_WIDTH-1:0] IDX_MAX = '1;
    localparam logic [INDEX_WIDTH-1:0] IDX_LO  = INDEX_WIDTH'(MIN_BIN);
    localparam logic [INDEX_WIDTH-1:0] IDX_HI  = INDEX_WIDTH'(MAX_BIN);
    localparam logic [MAG_WIDTH-1:0]   MAG_TH  = MAG_WIDTH'(MIN_MAG);

    logic [1:0]             state;
    logic [INDEX_WIDTH-1:0] idx;
    logic [INDEX_WIDTH-1:0] best_idx;
    logic [MAG_WIDTH-1:0]   run_max;
    logic                   ovf;
    logic [FREQ_WIDTH-1:0]  hz;
    logic                   accept;
    logic                   in_window;
    logic                   peak_ok;

    assign mag_ready = (state == ST_SCAN);
    assign accept    = mag_valid && mag_ready;
    assign in_window = (idx >= IDX_LO) && (idx <= IDX_HI);
    assign peak_ok   = (run_max > MAG_TH) && !ovf;

    bin_to_hz #(
        .INDEX_WIDTH   (INDEX_WIDTH),
        .FREQ_WIDTH    (FREQ_WIDTH),
        .BIN_WIDTH_Q16 (BIN_WIDTH_Q16)
    ) u_bin_to_hz (
        .clk   (clk),
        .reset (reset),
        .load  (state == ST_CALC),
        .index (best_idx),
        .freq  (hz)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_SCAN;
            idx           <= '0;
            best_idx      <= '0;
            run_max       <= '0;
            ovf           <= 1'b0;
            freq_out      <= '0;
            freq_valid    <= 1'b0;
            peak_mag      <= '0;
            frame_overrun <= 1'b0;
        end else begin
            frame_overrun <= 1'b0;
            case (state)
                ST_SCAN: begin
                    if (accept) begin
                        // Strict compare keeps the lowest index on ties.
                        if (in_window && (mag_data > run_max)) begin
                            run_max  <= mag_data;
                            best_idx <= idx;
                        end
                        if (idx == IDX_MAX) begin
                            if (!mag_last) ovf <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                        if (mag_last) state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    state <= ST_OUT;
                end
                ST_OUT: begin
                    freq_valid    <= peak_ok;
                    freq_out      <= peak_ok ? hz : '0;
                    peak_mag      <= peak_ok ? run_max : '0;
                    frame_overrun <= ovf;
                    idx           <= '0;
                    best_idx      <= '0;
                    run_max       <= '0;
                    ovf           <= 1'b0;
                    state         <= ST_SCAN;
                end
                default: begin
                    state <= ST_SCAN;
                end
            endcase
        end
    end

endmodule

// File: doc/spectral_peak_picker.md
Name: spectral_peak_picker

Overview:
- Frequency producer for the tuner display path.
- Consumes one FFT magnitude frame per call as a stream of bins. Tracks the largest bin inside a search window and converts its index to integer Hz.
- Drives the freq_out/freq_valid level interface that the note-display/LED tuner logic consumes.
- Sits between the FFT magnitude stage and the tuner.

Parameters:
- INDEX_WIDTH, 11, bin index width; frame length ≤ 2^INDEX_WIDTH bins.
- FREQ_WIDTH, INDEX_WIDTH+16, output frequency width (integer Hz, zero-extended).
- MAG_WIDTH, 24, unsigned magnitude width.
- BIN_WIDTH_Q16, 32'h0001_0000, Hz per bin, unsigned Q16.16.
- MIN_BIN, 20, lowest bin index searched (inclusive).
- MAX_BIN, 400, highest bin index searched (inclusive).
- MIN_MAG, 1000, a peak must be strictly greater than this to be valid.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset (see Behaviour).
- mag_data  in  MAG_WIDTH  bin magnitude, unsigned.
- mag_valid  in  1  mag_data valid.
- mag_last  in  1  marks the final bin of the frame.
- mag_ready  out  1  block accepts a beat; a beat transfers when mag_valid && mag_ready.
- freq_out  out  FREQ_WIDTH  peak frequency in Hz, rounded.
- freq_valid  out  1  level: freq_out holds a valid peak from the last completed frame.
- peak_mag  out  MAG_WIDTH  magnitude of the reported peak; 0 when freq_valid=0.
- frame_overrun  out  1  one-cycle pulse: the frame exceeded 2^INDEX_WIDTH bins.

Behaviour:
- Reset: reset, synchronous, active-high; clock clk.
- Reset values: freq_out=0, freq_valid=0, peak_mag=0, frame_overrun=0, mag_ready=1, state=SCAN, bin index=0, running max=0, best index=0, overflow flag=0.
- FSM states: SCAN -> CALC -> OUT -> SCAN.
- SCAN, general:
  - mag_ready=1.
  - Each accepted beat uses the current bin index, then increments it.
- SCAN, peak tracking:
  - Candidate when MIN_BIN ≤ index ≤ MAX_BIN and mag_data > running max. Strict compare, so on ties the lowest index wins.
  - Candidate updates running max and best index.
- SCAN, overflow:
  - Index saturates at 2^INDEX_WIDTH-1.
  - A beat accepted at the saturated index with mag_last=0 sets the sticky overflow flag.
- SCAN, end of frame: an accepted beat with mag_last=1 is processed as above; next state is CALC.
- CALC:
  - mag_ready=0.
  - Register product = best_index × BIN_WIDTH_Q16, width INDEX_WIDTH+32.
- OUT, outputs:
  - mag_ready=0.
  - freq_out = (product + 2^15) >> 16, truncated to FREQ_WIDTH.
  - valid = (running max > MIN_MAG) && !overflow.
  - If valid: freq_valid=1, peak_mag=running max.
  - Else: freq_valid=0, freq_out=0, peak_mag=0.
  - frame_overrun pulses for one cycle if overflow was set.
- OUT, clear: index, running max, best index and overflow cleared; next state SCAN.
- Latency: outputs change on the 2nd rising edge after the edge that accepted mag_last. mag_ready is low for exactly those 2 cycles.
- Output hold: freq_out/freq_valid/peak_mag hold between frames; they change only in OUT or on reset.
- Frame shorter than MIN_BIN bins: no candidate; freq_valid=0 at OUT.
- mag_valid=0 cycles inside a frame: no effect on state or index.
- Reset mid-frame: the partial frame is discarded and outputs clear. The next accepted beat is bin 0.
- Arithmetic: all unsigned. No signed compare anywhere.

Decomposition:
- Shared package tuner_pkg:
  - FSM state encoding (SCAN/CALC/OUT).
  - Q16 fractional-bit constant (16) and rounding constant (2^15).
  - Default MAG_WIDTH.
  - Shared note-frequency constants also consumed by the tuner.
- One sub-module: bin_to_hz, the registered index × Q16 multiply plus round/shift (CALC+OUT datapath).
  - Isolated so the DSP mapping and rounding are unit-testable.

Test Plan:
- Single peak:
  - Stimulus: BIN_WIDTH_Q16=1.0; 512-bin frame with all bins 10 except bin 41=5000.
  - Required: 2 cycles after mag_last, freq_out=41, freq_valid=1, peak_mag=5000; mag_ready low exactly 2 cycles.
- Tie and window:
  - Stimulus: bin 5=9000 (below MIN_BIN); bins 55 and 110 both 3000.
  - Required: freq_out=55, peak_mag=3000; bin 5 ignored.
- Threshold:
  - Stimulus: max in-window bin=1000 (equal to MIN_MAG), after a prior valid frame reporting 41.
  - Required: freq_valid=0, freq_out=0, peak_mag=0.
- Rounding:
  - Stimulus: BIN_WIDTH_Q16=0x0001_8000 (1.5 Hz); peak at bin 55.
  - Required: freq_out=83 (82.5 rounded up).
  - Stimulus: peak at bin 65, same bin width.
  - Required: freq_out=98 (97.5 rounded up).
- Overrun:
  - Stimulus: 2049 beats with mag_last only on beat 2049, strong peak at bin 98.
  - Required: frame_overrun pulses once at OUT, freq_valid=0.
  - Next normal frame with peak at bin 98: freq_out=98, freq_valid=1.
- Reset and backpressure:
  - Stimulus: assert reset at bin 200 of a frame, then a fresh frame with peak at bin 73, with mag_valid toggled randomly.
  - Required: reset gives all outputs 0 the next cycle; fresh frame gives freq_out=73, freq_valid=1; no beat is accepted while mag_ready=0.
